// File: rtl/univ_register.sv
// -----------------------------------------------------------------------------
// univ_register
//
// General-purpose datapath register for SAP-2 class machines: accumulator,
// temp, output or counter-style registers. Besides plain load/hold it can
// increment, decrement, shift and rotate. It keeps a registered carry flag,
// derives a combinational zero flag, and drives a gated (AND-gated, not
// tristate) bus output.
//
// Parameters
//   WIDTH      data width in bits, 2..32
//   RESET_VAL  value taken by the register on reset
//
// Ports
//   clk_i       rising-edge clock for all state
//   rst_i       synchronous reset, active-high; overrides op_i
//   op_i        operation select:
//               000 HOLD, 001 LOAD, 010 INC, 011 DEC,
//               100 SHL, 101 SHR, 110 ROL, 111 ROR
//   bus_i       load data
//   ser_i       serial-in bit for SHL/SHR
//   oe_i        bus output enable (does not affect state)
//   bus_o       register value when oe_i=1, otherwise zero
//   parallel_o  register value, always driven
//   carry_o     registered carry / borrow / shifted-out bit
//   zero_o      high when the register value is zero
// -----------------------------------------------------------------------------
module univ_register #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] bus_i,
    input  logic             ser_i,
    input  logic             oe_i,
    output logic [WIDTH-1:0] bus_o,
    output logic [WIDTH-1:0] parallel_o,
    output logic             carry_o,
    output logic             zero_o
);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_ROL  = 3'b110;
    localparam logic [2:0] OP_ROR  = 3'b111;

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;
    logic             carry_reg;
    logic             carry_next;

    // One extra bit on the incrementer gives the wrap-out directly.
    logic [WIDTH:0]   inc_sum;
    logic [WIDTH-1:0] dec_val;
    logic             dec_borrow;

    assign inc_sum    = {1'b0, data_reg} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_val    = data_reg - {{(WIDTH-1){1'b0}}, 1'b1};
    assign dec_borrow = (data_reg == '0);

    // Shift and rotate networks. Bit 0 / bit WIDTH-1 are the entry points
    // (serial-in or wrapped bit), everything else moves by one position.
    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] shr_val;
    logic [WIDTH-1:0] rol_val;
    logic [WIDTH-1:0] ror_val;

    assign shl_val[0]       = ser_i;
    assign rol_val[0]       = data_reg[WIDTH-1];
    assign shr_val[WIDTH-1] = ser_i;
    assign ror_val[WIDTH-1] = data_reg[0];

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_left
            assign shl_val[gi] = data_reg[gi-1];
            assign rol_val[gi] = data_reg[gi-1];
        end
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_right
            assign shr_val[gi] = data_reg[gi+1];
            assign ror_val[gi] = data_reg[gi+1];
        end
    endgenerate

    always_comb begin
        data_next  = data_reg;
        carry_next = carry_reg;
        unique case (op_i)
            OP_HOLD: begin
                data_next  = data_reg;
                carry_next = carry_reg;
            end
            OP_LOAD: begin
                data_next  = bus_i;
                carry_next = 1'b0;
            end
            OP_INC: begin
                data_next  = inc_sum[WIDTH-1:0];
                carry_next = inc_sum[WIDTH];
            end
            OP_DEC: begin
                data_next  = dec_val;
                carry_next = dec_borrow;
            end
            OP_SHL: begin
                data_next  = shl_val;
                carry_next = data_reg[WIDTH-1];
            end
            OP_SHR: begin
                data_next  = shr_val;
                carry_next = data_reg[0];
            end
            OP_ROL: begin
                data_next  = rol_val;
                carry_next = data_reg[WIDTH-1];
            end
            OP_ROR: begin
                data_next  = ror_val;
                carry_next = data_reg[0];
            end
            default: begin
                data_next  = data_reg;
                carry_next = carry_reg;
            end
        endcase
    end

    // Reset wins over whatever operation is presented in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_reg  <= RESET_VAL;
            carry_reg <= 1'b0;
        end else begin
            data_reg  <= data_next;
            carry_reg <= carry_next;
        end
    end

    assign parallel_o = data_reg;
    assign carry_o    = carry_reg;
    assign zero_o     = (data_reg == '0);

    // Output gating is a plain AND per bit; an undriven bus reads as zero.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bus_gate
            assign bus_o[gi] = data_reg[gi] & oe_i;
        end
    endgenerate

endmodule

// File: tb/tb_univ_register.sv
// -----------------------------------------------------------------------------
// tb_univ_register
//
// Three instances (WIDTH 8, 4 and 16) share op/ser/oe/rst stimulus; each gets
// the low bits of a common 32-bit bus word. An arithmetic reference model
// (modulo 2^W, multiply/divide for shifts) tracks every instance and a
// negedge process compares all outputs each cycle. Directed sequences with
// literal expectations pin the model, then a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_univ_register;

    localparam logic [7:0]  RV8  = 8'hA5;
    localparam logic [3:0]  RV4  = 4'h9;
    localparam logic [15:0] RV16 = 16'h1234;

    localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, INC = 3'd2, DEC = 3'd3,
                           SHL  = 3'd4, SHR  = 3'd5, ROL = 3'd6, ROR = 3'd7;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [2:0]  op_i;
    logic [31:0] bus_w;
    logic        ser_i;
    logic        oe_i;

    logic [7:0]  bus8_o,  par8_o;
    logic [3:0]  bus4_o,  par4_o;
    logic [15:0] bus16_o, par16_o;
    logic        c8_o, z8_o, c4_o, z4_o, c16_o, z16_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    univ_register #(.WIDTH(8), .RESET_VAL(RV8)) dut8 (
        .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .bus_i(bus_w[7:0]),
        .ser_i(ser_i), .oe_i(oe_i), .bus_o(bus8_o), .parallel_o(par8_o),
        .carry_o(c8_o), .zero_o(z8_o)
    );

    univ_register #(.WIDTH(4), .RESET_VAL(RV4)) dut4 (
        .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .bus_i(bus_w[3:0]),
        .ser_i(ser_i), .oe_i(oe_i), .bus_o(bus4_o), .parallel_o(par4_o),
        .carry_o(c4_o), .zero_o(z4_o)
    );

    univ_register #(.WIDTH(16), .RESET_VAL(RV16)) dut16 (
        .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .bus_i(bus_w[15:0]),
        .ser_i(ser_i), .oe_i(oe_i), .bus_o(bus16_o), .parallel_o(par16_o),
        .carry_o(c16_o), .zero_o(z16_o)
    );

    // ------------------------------------------------------------------
    // Reference model: plain arithmetic on integers modulo 2^w.
    // ------------------------------------------------------------------
    function automatic void model_step(input int w, input longint r, input bit c,
                                       input logic [2:0] op, input longint bus,
                                       input bit ser, output longint nr, output bit nc);
        longint m;
        longint h;
        m = longint'(1) << w;
        h = m / 2;
        nr = r;
        nc = c;
        case (op)
            HOLD: begin nr = r;                       nc = c;            end
            LOAD: begin nr = bus % m;                 nc = 1'b0;         end
            INC:  begin nr = (r + 1) % m;             nc = (r == m - 1); end
            DEC:  begin nr = (r + m - 1) % m;         nc = (r == 0);     end
            SHL:  begin nr = (r * 2 + ser) % m;       nc = (r >= h);     end
            SHR:  begin nr = r / 2 + ser * h;         nc = (r % 2) == 1; end
            ROL:  begin nr = (r * 2) % m + r / h;     nc = (r >= h);     end
            ROR:  begin nr = r / 2 + (r % 2) * h;     nc = (r % 2) == 1; end
            default: begin nr = r; nc = c; end
        endcase
    endfunction

    longint m8, m4, m16;
    bit     mc8, mc4, mc16;
    bit     armed = 1'b0;

    always @(posedge clk) begin : model
        longint nr;
        bit     nc;
        if (rst_i) begin
            m8  <= longint'(RV8);
            m4  <= longint'(RV4);
            m16 <= longint'(RV16);
            mc8 <= 1'b0; mc4 <= 1'b0; mc16 <= 1'b0;
            armed <= 1'b1;
        end else if (armed) begin
            if ($isunknown(op_i)) begin
                fails++;
                $display("FAIL op_known: op_i=%b while rst_i=0, required a known value", op_i);
            end
            model_step(8,  m8,  mc8,  op_i, longint'(bus_w), ser_i, nr, nc);
            m8 <= nr;  mc8 <= nc;
            model_step(4,  m4,  mc4,  op_i, longint'(bus_w), ser_i, nr, nc);
            m4 <= nr;  mc4 <= nc;
            model_step(16, m16, mc16, op_i, longint'(bus_w), ser_i, nr, nc);
            m16 <= nr; mc16 <= nc;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output of every instance against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("par8",   longint'(par8_o),  m8);
            chk("carry8", longint'(c8_o),    longint'(mc8));
            chk("zero8",  longint'(z8_o),    longint'(m8 == 0));
            chk("bus8",   longint'(bus8_o),  oe_i ? m8 : 0);
            chk("par4",   longint'(par4_o),  m4);
            chk("carry4", longint'(c4_o),    longint'(mc4));
            chk("zero4",  longint'(z4_o),    longint'(m4 == 0));
            chk("bus4",   longint'(bus4_o),  oe_i ? m4 : 0);
            chk("par16",  longint'(par16_o), m16);
            chk("carry16",longint'(c16_o),   longint'(mc16));
            chk("zero16", longint'(z16_o),   longint'(m16 == 0));
            chk("bus16",  longint'(bus16_o), oe_i ? m16 : 0);
        end
    end

    // Present one operation, let one edge consume it, return 1 time unit later.
    task automatic apply(input logic [2:0] op, input logic [31:0] b,
                         input logic s, input logic r);
        op_i  = op;
        bus_w = b;
        ser_i = s;
        rst_i = r;
        @(posedge clk);
        #1;
        $display("[TB] t=%0t rst=%0b op=%0d bus=%08h ser=%0b oe=%0b -> r8=%02h c8=%0b r4=%01h r16=%04h",
                 $time, r, op, b, s, oe_i, par8_o, c8_o, par4_o, par16_o);
    endtask

    initial begin
        rst_i = 1'b1;
        op_i  = HOLD;
        bus_w = '0;
        ser_i = 1'b0;
        oe_i  = 1'b0;

        // Reset state
        apply(HOLD, 32'h0, 1'b0, 1'b1);
        chk("rst_par8",   longint'(par8_o), 64'hA5);
        chk("rst_carry8", longint'(c8_o),   0);
        chk("rst_zero8",  longint'(z8_o),   0);
        chk("rst_bus8",   longint'(bus8_o), 0);

        // Load then hold, enable the bus on the last hold
        apply(LOAD, 32'h3C, 1'b0, 1'b0);
        chk("load_par", longint'(par8_o), 64'h3C);
        apply(HOLD, 32'h0, 1'b0, 1'b0);
        apply(HOLD, 32'h0, 1'b0, 1'b0);
        oe_i = 1'b1;
        apply(HOLD, 32'h0, 1'b0, 1'b0);
        chk("hold_par",   longint'(par8_o), 64'h3C);
        chk("hold_carry", longint'(c8_o),   0);
        chk("hold_bus",   longint'(bus8_o), 64'h3C);

        // Wrap-around
        apply(LOAD, 32'hFF, 1'b0, 1'b0);
        apply(INC,  32'h0,  1'b0, 1'b0);
        chk("inc_wrap_par",   longint'(par8_o), 0);
        chk("inc_wrap_carry", longint'(c8_o),   1);
        chk("inc_wrap_zero",  longint'(z8_o),   1);
        apply(DEC,  32'h0,  1'b0, 1'b0);
        chk("dec_wrap_par",   longint'(par8_o), 64'hFF);
        chk("dec_wrap_carry", longint'(c8_o),   1);
        apply(DEC,  32'h0,  1'b0, 1'b0);
        chk("dec_par",   longint'(par8_o), 64'hFE);
        chk("dec_carry", longint'(c8_o),   0);

        // Shifts and rotates
        apply(LOAD, 32'h81, 1'b0, 1'b0);
        apply(SHL,  32'h0,  1'b0, 1'b0);
        chk("shl_par", longint'(par8_o), 64'h02);
        chk("shl_carry", longint'(c8_o), 1);
        apply(SHR,  32'h0,  1'b1, 1'b0);
        chk("shr_par", longint'(par8_o), 64'h81);
        chk("shr_carry", longint'(c8_o), 0);
        apply(ROR,  32'h0,  1'b0, 1'b0);
        chk("ror_par", longint'(par8_o), 64'hC0);
        chk("ror_carry", longint'(c8_o), 1);
        apply(ROL,  32'h0,  1'b0, 1'b0);
        chk("rol_par", longint'(par8_o), 64'h81);
        chk("rol_carry", longint'(c8_o), 1);

        // Reset beats a concurrent INC
        apply(LOAD, 32'h55, 1'b0, 1'b0);
        apply(INC,  32'h0,  1'b0, 1'b1);
        chk("rstpri_par",   longint'(par8_o), 64'hA5);
        chk("rstpri_carry", longint'(c8_o),   0);

        // Width sweep on the 4- and 16-bit instances
        apply(LOAD, 32'h0000FFFF, 1'b0, 1'b0);
        apply(INC,  32'h0, 1'b0, 1'b0);
        chk("w4_inc_par",    longint'(par4_o),  0);
        chk("w4_inc_carry",  longint'(c4_o),    1);
        chk("w16_inc_par",   longint'(par16_o), 0);
        chk("w16_inc_carry", longint'(c16_o),   1);
        apply(LOAD, 32'h00008000, 1'b0, 1'b0);
        apply(ROL,  32'h0, 1'b0, 1'b0);
        chk("w16_rol_par", longint'(par16_o), 1);
        apply(LOAD, 32'h00000008, 1'b0, 1'b0);
        apply(ROL,  32'h0, 1'b0, 1'b0);
        chk("w4_rol_par",  longint'(par4_o), 1);

        // Randomized phase, with boundary-biased load data
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] b;
            case ($urandom_range(0, 5))
                0:       b = 32'hFFFFFFFF;
                1:       b = 32'h0;
                2:       b = 32'h80008008;
                default: b = $urandom;
            endcase
            oe_i = 1'($urandom_range(0, 1));
            apply(3'($urandom_range(0, 7)), b, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 39) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
